rvga_debug_trace_ctrl: RTL and testbench
========================================

// Module: rvga_debug_trace_ctrl
// PURPOSE
// Trace capture controller for the decoded-instruction debug bus (rvga_debugbus_if).
// Samples the bus on every retire strobe into a circular trace buffer.
// Sequences pre-trigger / post-trigger capture around a programmable opcode trigger.
// Freezes the buffer, then drains it to the debug host over a valid/ready port.
// PARAMETERS
// DEPTH   16  trace buffer entries; power of two, >= 2
// TS_W    16  timestamp counter width, bits
// PORTS
// clk_i        in   1        core clock
// rst_ni       in   1        asynchronous, active-low reset
// dbg          in   if.i     rvga_debugbus_if.i: opcode, inst_type, brop, ldop, strop, artop
// valid_i      in   1        retire strobe; dbg fields are meaningful only while high
// arm_i        in   1        start capture (pulse)
// disarm_i     in   1        abort and clear (pulse)
// trig_en_i    in   1        1: trigger on opcode match; 0: trigger on first valid entry
// trig_op_i    in   opcode_e trigger opcode
// post_cnt_i   in   clog2(DEPTH)+1  entries to capture after the trigger entry
// rd_valid_o   out  1        drain entry available
// rd_ready_i   in   1        host accepts the entry
// rd_data_o    out  $bits(rvga_trace_entry_t)  oldest entry {ts, opcode, inst_type, brop, ldop, strop, artop}
// state_o      out  2        IDLE=0, PRE=1, POST=2, DONE=3
// count_o      out  clog2(DEPTH)+1  entries held
// overflow_o   out  1        sticky; pre-trigger history was overwritten
// BEHAVIOUR
// Reset (async, rst_ni=0): state IDLE, pointers/count 0, ts 0, overflow_o 0, rd_valid_o 0.
// rd_data_o is don't-care while rd_valid_o=0.
// Write latency: an entry presented with valid_i in cycle N is in the buffer and counted at N+1.
// IDLE:
// - arm_i -> PRE; buffer cleared, overflow_o cleared, ts cleared.
// - valid_i is ignored.
// PRE:
// - Every valid_i writes an entry.
// - Buffer full: overwrite the oldest entry, advance the read pointer, set overflow_o.
// - Trigger (valid_i && (!trig_en_i || dbg.opcode==trig_op_i)):
//   - The trigger entry itself is written.
//   - post_cnt_i is latched.
//   - Next state: POST, or DONE if the latched value is 0.
// POST:
// - Each valid_i writes one entry and decrements the post counter.
// - Counter reaches 0 -> DONE.
// - Buffer full before the counter reaches 0 -> DONE with no overwrite; the post-window is truncated.
// DONE:
// - Capture is frozen; valid_i is ignored.
// - rd_valid_o = (count_o != 0).
// - Pop on rd_valid_o && rd_ready_i.
// - Popping the last entry -> IDLE at the next edge.
// - rd_valid_o is never high outside DONE.
// disarm_i in any state -> IDLE, buffer cleared; disarm_i has priority over arm_i and over the trigger.
// arm_i outside IDLE is ignored; re-arming requires a drain or a disarm first.
// ts:
// - Free-running in PRE and POST; wraps modulo 2^TS_W without a flag.
// - Held in IDLE and DONE.
// - An entry records ts of its valid cycle.
// Pointers are clog2(DEPTH) bits and wrap naturally; count_o saturates at DEPTH.
// A simultaneous write and pop cannot occur, because the two are state-exclusive.
// STRUCTURE
// Shared package rvga_types:
// - rvga_trace_entry_t: packed struct {ts, opcode, inst_type, brop, ldop, strop, artop}.
// - rvga_trace_state_e: IDLE, PRE, POST, DONE.
// Sub-module rvga_trace_buf: circular flop-array FIFO.
// - Inputs: push, pop, overwrite_en, clear.
// - Outputs: count, full, empty, head data.
// The FSM, trigger match, post counter and ts live in the top level.
// TESTING
// - Reset mid-POST -> next cycle state_o=0, count_o=0, overflow_o=0, rd_valid_o=0.
// - Pre-trigger with overwrite:
//   - Stimulus: DEPTH=16, trig_en=1, trig_op=BRANCH, 20 ALU retires, then BRANCH, post_cnt=0.
//   - Response: DONE with count 16, overflow_o=1; first drained entry is ALU #6; last drained entry is BRANCH.
// - Post window:
//   - Stimulus: trig_en=0, post_cnt=3, 10 retires.
//   - Response: 4 entries captured (retires 1..4); state DONE one cycle after retire 4.
// - POST truncation:
//   - Stimulus: 14 entries held in PRE, trigger, post_cnt=8.
//   - Response: DONE at count 16 after 1 post entry; overflow_o=0.
// - Drain backpressure:
//   - Stimulus: rd_ready toggles 1,0,1 across 3 entries.
//   - Response: entries returned in order, no duplicates; IDLE the cycle after the final pop.
// - Arm and disarm in the same cycle in IDLE -> remains IDLE.

Source files
------------

// File: rtl/rvga_types.sv
// Shared types for the decoded-instruction debug bus and the trace capture path.
// The timestamp field width is fixed here; the controller's counter is sized into it.
package rvga_types;

    localparam int TRACE_TS_W = 16;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011,
        OPC_ALU    = 7'b0110011,
        OPC_ALUI   = 7'b0010011,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    typedef enum logic [1:0] {
        TRACE_IDLE = 2'd0,
        TRACE_PRE  = 2'd1,
        TRACE_POST = 2'd2,
        TRACE_DONE = 2'd3
    } rvga_trace_state_e;

    typedef struct packed {
        logic [TRACE_TS_W-1:0] ts;
        opcode_e               opcode;
        logic [2:0]            inst_type;
        logic [2:0]            brop;
        logic [2:0]            ldop;
        logic [1:0]            strop;
        logic [3:0]            artop;
    } rvga_trace_entry_t;

endpackage

// File: rtl/rvga_debugbus_if.sv
// Decoded-instruction debug bus as seen by trace consumers (modport i) and the
// decoder driving it (modport o).
interface rvga_debugbus_if;
    import rvga_types::*;

    opcode_e    opcode;
    logic [2:0] inst_type;
    logic [2:0] brop;
    logic [2:0] ldop;
    logic [1:0] strop;
    logic [3:0] artop;

    modport i (input  opcode, inst_type, brop, ldop, strop, artop);
    modport o (output opcode, inst_type, brop, ldop, strop, artop);
endinterface

// File: rtl/rvga_trace_buf.sv
// Circular flop-array FIFO for trace entries; a push into a full buffer either
// overwrites the oldest entry (overwrite enabled) or is dropped.
module rvga_trace_buf
    import rvga_types::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_overwrite_en,
    input  logic                     i_clear,
    input  rvga_trace_entry_t        i_wdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output rvga_trace_entry_t        o_head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    rvga_trace_entry_t r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !i_clear && (!o_full || i_overwrite_en);
    assign w_do_pop  = i_pop && !i_clear && !i_push && !o_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            // Overwriting push: the oldest slot is reused, so the read side moves with it.
            if (o_full) r_rd_ptr <= r_rd_ptr + 1'b1;
            else        r_count  <= r_count + 1'b1;
        end else if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count  <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/rvga_debug_trace_ctrl.sv
// Trace capture controller: samples the debug bus on each retire, sequences
// pre/post-trigger capture, then drains the frozen buffer to the debug host.
module rvga_debug_trace_ctrl
    import rvga_types::*;
#(
    parameter int DEPTH = 16,
    parameter int TS_W  = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    rvga_debugbus_if.i                           dbg,
    input  logic                                 valid_i,
    input  logic                                 arm_i,
    input  logic                                 disarm_i,
    input  logic                                 trig_en_i,
    input  opcode_e                              trig_op_i,
    input  logic [$clog2(DEPTH):0]               post_cnt_i,
    output logic                                 rd_valid_o,
    input  logic                                 rd_ready_i,
    output logic [$bits(rvga_trace_entry_t)-1:0] rd_data_o,
    output logic [1:0]                           state_o,
    output logic [$clog2(DEPTH):0]               count_o,
    output logic                                 overflow_o
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    rvga_trace_state_e r_state;
    rvga_trace_state_e w_next;
    logic [TS_W-1:0]   r_ts;
    logic [CNT_W-1:0]  r_post;
    logic              r_overflow;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_trig;
    logic              w_push;
    logic              w_pop;
    logic              w_clear;
    logic              w_latch;
    logic              w_post_dec;
    logic              w_ovf_set;
    logic              w_ovf_clr;
    logic              w_ts_clr;
    rvga_trace_entry_t w_entry;
    rvga_trace_entry_t w_head;

    assign w_trig = valid_i && (!trig_en_i || (dbg.opcode == trig_op_i));

    always_comb begin
        w_entry           = '0;
        w_entry.ts        = TRACE_TS_W'(r_ts);
        w_entry.opcode    = dbg.opcode;
        w_entry.inst_type = dbg.inst_type;
        w_entry.brop      = dbg.brop;
        w_entry.ldop      = dbg.ldop;
        w_entry.strop     = dbg.strop;
        w_entry.artop     = dbg.artop;
    end

    always_comb begin
        w_next     = r_state;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_clear    = 1'b0;
        w_latch    = 1'b0;
        w_post_dec = 1'b0;
        w_ovf_set  = 1'b0;
        w_ovf_clr  = 1'b0;
        w_ts_clr   = 1'b0;
        if (disarm_i) begin
            w_next    = TRACE_IDLE;
            w_clear   = 1'b1;
            w_ovf_clr = 1'b1;
        end else begin
            case (r_state)
                TRACE_IDLE: begin
                    if (arm_i) begin
                        w_next    = TRACE_PRE;
                        w_clear   = 1'b1;
                        w_ovf_clr = 1'b1;
                        w_ts_clr  = 1'b1;
                    end
                end
                TRACE_PRE: begin
                    if (valid_i) begin
                        w_push    = 1'b1;
                        w_ovf_set = w_full;
                        if (w_trig) begin
                            w_latch = 1'b1;
                            w_next  = (post_cnt_i == '0) ? TRACE_DONE : TRACE_POST;
                        end
                    end
                end
                TRACE_POST: begin
                    // A full buffer ends the post window early instead of losing history.
                    if (w_full) begin
                        w_next = TRACE_DONE;
                    end else if (valid_i) begin
                        w_push     = 1'b1;
                        w_post_dec = 1'b1;
                        if (r_post == CNT_W'(1) || w_count == CNT_W'(DEPTH - 1))
                            w_next = TRACE_DONE;
                    end
                end
                TRACE_DONE: begin
                    if (rd_valid_o && rd_ready_i) begin
                        w_pop = 1'b1;
                        if (w_count == CNT_W'(1)) w_next = TRACE_IDLE;
                    end
                end
                default: w_next = TRACE_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= TRACE_IDLE;
            r_ts       <= '0;
            r_post     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_ts_clr)
                r_ts <= '0;
            else if (r_state == TRACE_PRE || r_state == TRACE_POST)
                r_ts <= r_ts + 1'b1;
            if (w_latch)         r_post <= post_cnt_i;
            else if (w_post_dec) r_post <= r_post - 1'b1;
            if (w_ovf_clr)       r_overflow <= 1'b0;
            else if (w_ovf_set)  r_overflow <= 1'b1;
        end
    end

    rvga_trace_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .i_push         (w_push),
        .i_pop          (w_pop),
        .i_overwrite_en (r_state == TRACE_PRE),
        .i_clear        (w_clear),
        .i_wdata        (w_entry),
        .o_count        (w_count),
        .o_full         (w_full),
        .o_empty        (w_empty),
        .o_head         (w_head)
    );

    // Drain handshake: an entry transfers on a cycle where rd_valid_o && rd_ready_i;
    // rd_valid_o depends only on state and count, never on rd_ready_i.
    assign rd_valid_o = (r_state == TRACE_DONE) && !w_empty;
    assign rd_data_o  = w_head;
    assign state_o    = r_state;
    assign count_o    = w_count;
    assign overflow_o = r_overflow;

endmodule

// File: tb/tb_rvga_debug_trace_ctrl.sv
// Bench for the trace controller: queue-based reference model with a per-cycle
// compare process, directed scenarios with literal expectations, and random runs.
module tb_rvga_debug_trace_ctrl;
    import rvga_types::*;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int EW    = $bits(rvga_trace_entry_t);

    // clock / reset
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    // DUT connections
    rvga_debugbus_if dbg_if ();
    logic          valid_i = 1'b0;
    logic          arm_i = 1'b0;
    logic          disarm_i = 1'b0;
    logic          trig_en_i = 1'b0;
    opcode_e       trig_op_i = OPC_BRANCH;
    logic [CW-1:0] post_cnt_i = '0;
    logic          rd_valid_o;
    logic          rd_ready_i = 1'b0;
    logic [EW-1:0] rd_data_o;
    logic [1:0]    state_o;
    logic [CW-1:0] count_o;
    logic          overflow_o;

    rvga_debug_trace_ctrl #(.DEPTH(DEPTH), .TS_W(16)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .dbg        (dbg_if),
        .valid_i    (valid_i),
        .arm_i      (arm_i),
        .disarm_i   (disarm_i),
        .trig_en_i  (trig_en_i),
        .trig_op_i  (trig_op_i),
        .post_cnt_i (post_cnt_i),
        .rd_valid_o (rd_valid_o),
        .rd_ready_i (rd_ready_i),
        .rd_data_o  (rd_data_o),
        .state_o    (state_o),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    // scoreboard state
    int            n_cmp = 0;
    int            n_fail = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] got_q[$];
    int            m_state = 0;   // 0 idle, 1 pre, 2 post, 3 done
    bit [15:0]     m_ts = '0;
    bit            m_ovf = 1'b0;
    int            m_post = 0;

    opcode_e op_tab[10] = '{OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_ALU, OPC_ALUI,
                            OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_SYSTEM};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: cycle bound expired (t=%0t)", name, $time);
    endtask

    // reference model: the capture buffer is a plain queue of entries
    task automatic model_reset();
        exp_q.delete();
        m_state = 0;
        m_ts    = '0;
        m_ovf   = 1'b0;
        m_post  = 0;
    endtask

    task automatic model_step();
        rvga_trace_entry_t e;
        bit                trig;
        e           = '0;
        e.ts        = m_ts;
        e.opcode    = dbg_if.opcode;
        e.inst_type = dbg_if.inst_type;
        e.brop      = dbg_if.brop;
        e.ldop      = dbg_if.ldop;
        e.strop     = dbg_if.strop;
        e.artop     = dbg_if.artop;
        trig = valid_i && (!trig_en_i || dbg_if.opcode == trig_op_i);
        if (m_state == 1 || m_state == 2) m_ts = m_ts + 16'd1;
        if (disarm_i) begin
            exp_q.delete();
            m_ovf   = 1'b0;
            m_state = 0;
        end else begin
            case (m_state)
                0: if (arm_i) begin
                    exp_q.delete();
                    m_ovf   = 1'b0;
                    m_ts    = '0;
                    m_state = 1;
                end
                1: if (valid_i) begin
                    if (exp_q.size() == DEPTH) begin
                        void'(exp_q.pop_front());
                        m_ovf = 1'b1;
                    end
                    exp_q.push_back(e);
                    if (trig) begin
                        m_post  = int'(post_cnt_i);
                        m_state = (m_post == 0) ? 3 : 2;
                    end
                end
                2: if (exp_q.size() == DEPTH) begin
                    m_state = 3;
                end else if (valid_i) begin
                    exp_q.push_back(e);
                    m_post--;
                    if (m_post == 0 || exp_q.size() == DEPTH) m_state = 3;
                end
                default: if (exp_q.size() != 0 && rd_ready_i) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) m_state = 0;
                end
            endcase
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_ni);
            if (!rst_ni) model_reset();
            else         model_step();
        end
    end

    // compare process: every cycle, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            check("state", 64'(state_o), 64'(m_state));
            check("count", 64'(count_o), 64'(exp_q.size()));
            check("overflow", 64'(overflow_o), 64'(m_ovf));
            check("rd_valid", 64'(rd_valid_o), 64'((m_state == 3) && (exp_q.size() != 0)));
            if (rd_valid_o && exp_q.size() != 0)
                check("rd_data", 64'(rd_data_o), 64'(exp_q[0]));
            if (rd_valid_o && rd_ready_i) got_q.push_back(rd_data_o);
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input opcode_e op);
        dbg_if.opcode    = op;
        dbg_if.inst_type = 3'($urandom);
        dbg_if.brop      = 3'($urandom);
        dbg_if.ldop      = 3'($urandom);
        dbg_if.strop     = 2'($urandom);
        dbg_if.artop     = 4'($urandom);
    endtask

    task automatic do_retire(input opcode_e op);
        valid_i = 1'b1;
        set_fields(op);
        step();
        valid_i = 1'b0;
    endtask

    task automatic do_arm();
        arm_i = 1'b1;
        step();
        arm_i = 1'b0;
    endtask

    task automatic drain_all(input string name);
        int n;
        n = 0;
        got_q.delete();
        rd_ready_i = 1'b1;
        while (m_state != 0 && n < 100) begin
            step();
            n++;
        end
        rd_ready_i = 1'b0;
        if (n >= 100) bound_fail(name);
    endtask

    task automatic check_got(input string name, input int idx, input opcode_e op, input int ts);
        rvga_trace_entry_t g;
        if (idx < got_q.size()) begin
            g = rvga_trace_entry_t'(got_q[idx]);
            check({name, "_op"}, 64'(g.opcode), 64'(op));
            check({name, "_ts"}, 64'(g.ts), 64'(ts));
        end else begin
            bound_fail({name, "_missing"});
        end
    endtask

    initial begin
        set_fields(OPC_ALU);
        repeat (3) step();
        rst_ni = 1'b1;
        step();
        check("rst_state", 64'(state_o), 64'(0));
        check("rst_count", 64'(count_o), 64'(0));
        check("rst_ovf", 64'(overflow_o), 64'(0));
        check("rst_rd_valid", 64'(rd_valid_o), 64'(0));

        // arm and disarm together in IDLE stays IDLE
        arm_i = 1'b1;
        disarm_i = 1'b1;
        step();
        arm_i = 1'b0;
        disarm_i = 1'b0;
        check("armdis_state", 64'(state_o), 64'(0));

        // pre-trigger overwrite: 20 ALU then BRANCH, post 0
        trig_en_i = 1'b1;
        trig_op_i = OPC_BRANCH;
        post_cnt_i = CW'(0);
        do_arm();
        for (int i = 0; i < 20; i++) do_retire(OPC_ALU);
        do_retire(OPC_BRANCH);
        check("ovw_state", 64'(state_o), 64'(3));
        check("ovw_count", 64'(count_o), 64'(16));
        check("ovw_ovf", 64'(overflow_o), 64'(1));
        drain_all("ovw_drain");
        check("ovw_ndrained", 64'(got_q.size()), 64'(16));
        check_got("ovw_first", 0, OPC_ALU, 5);
        check_got("ovw_last", 15, OPC_BRANCH, 20);

        // post window: trigger on first valid, 3 post entries
        trig_en_i = 1'b0;
        post_cnt_i = CW'(3);
        do_arm();
        for (int i = 0; i < 4; i++) do_retire(OPC_ALUI);
        check("post_state", 64'(state_o), 64'(3));
        check("post_count", 64'(count_o), 64'(4));
        for (int i = 0; i < 6; i++) do_retire(OPC_LOAD);
        check("post_frozen", 64'(count_o), 64'(4));
        drain_all("post_drain");
        check("post_ndrained", 64'(got_q.size()), 64'(4));
        for (int i = 0; i < 4; i++) check_got("post_entry", i, OPC_ALUI, i);

        // post truncation by a full buffer
        trig_en_i = 1'b1;
        trig_op_i = OPC_BRANCH;
        post_cnt_i = CW'(8);
        do_arm();
        for (int i = 0; i < 14; i++) do_retire(OPC_ALU);
        do_retire(OPC_BRANCH);
        check("trunc_post", 64'(state_o), 64'(2));
        check("trunc_cnt15", 64'(count_o), 64'(15));
        do_retire(OPC_ALU);
        check("trunc_state", 64'(state_o), 64'(3));
        check("trunc_count", 64'(count_o), 64'(16));
        check("trunc_ovf", 64'(overflow_o), 64'(0));
        drain_all("trunc_drain");

        // drain with backpressure on three entries
        trig_en_i = 1'b0;
        post_cnt_i = CW'(2);
        do_arm();
        for (int i = 0; i < 3; i++) do_retire(OPC_STORE);
        check("bp_count", 64'(count_o), 64'(3));
        got_q.delete();
        for (int i = 0; i < 5; i++) begin
            rd_ready_i = (i % 2 == 0);
            if (i == 4) check("bp_last_pending", 64'(count_o), 64'(1));
            step();
        end
        rd_ready_i = 1'b0;
        check("bp_idle", 64'(state_o), 64'(0));
        check("bp_ndrained", 64'(got_q.size()), 64'(3));
        for (int i = 0; i < 3; i++) check_got("bp_entry", i, OPC_STORE, i);

        // async reset mid-POST
        post_cnt_i = CW'(5);
        do_arm();
        do_retire(OPC_JAL);
        do_retire(OPC_JAL);
        check("rstpost_pre", 64'(state_o), 64'(2));
        rst_ni = 1'b0;
        step();
        check("rstpost_state", 64'(state_o), 64'(0));
        check("rstpost_count", 64'(count_o), 64'(0));
        check("rstpost_ovf", 64'(overflow_o), 64'(0));
        check("rstpost_rdv", 64'(rd_valid_o), 64'(0));
        rst_ni = 1'b1;
        step();

        // randomized capture / drain runs
        for (int it = 0; it < 40; it++) begin
            int n;
            trig_en_i = ($urandom_range(0, 3) != 0);
            trig_op_i = op_tab[$urandom_range(0, 9)];
            post_cnt_i = CW'($urandom_range(0, DEPTH));
            do_arm();
            n = 0;
            while ((m_state == 1 || m_state == 2) && n < 300) begin
                valid_i = ($urandom_range(0, 2) != 0);
                set_fields(op_tab[$urandom_range(0, 9)]);
                if (n > 80) trig_en_i = 1'b0;
                disarm_i = ($urandom_range(0, 99) < 2);
                arm_i = ($urandom_range(0, 9) == 0);
                step();
                n++;
            end
            if (n >= 300) bound_fail("rand_capture");
            n = 0;
            while (m_state == 3 && n < 300) begin
                valid_i = $urandom_range(0, 1);
                rd_ready_i = $urandom_range(0, 1);
                disarm_i = ($urandom_range(0, 99) < 2);
                arm_i = ($urandom_range(0, 9) == 0);
                step();
                n++;
            end
            valid_i = 1'b0;
            rd_ready_i = 1'b0;
            disarm_i = 1'b0;
            arm_i = 1'b0;
            if (n >= 300) bound_fail("rand_drain");
            step();
        end

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
